// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : aes_inv_cipher_iter (+ KeyGeneration, inv_subbytes,
//               inv_shiftrow, inv_mixcolumns)
// Description : Iterative AES-128 inverse cipher, one round per clock, with
//               forward key expansion into an 11-entry round-key bank and an
//               optional cache that skips expansion for a repeated key.
// Revision    : 1.0 - initial release
// ============================================================================

// Forward key schedule step: round key rc+1 from round key rc.
module KeyGeneration (
  input  logic [3:0]   rc_i,
  input  logic [127:0] key_i,
  output logic [127:0] key_o
);
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  // Round constant for the current expansion step
  always_comb begin
    case (rc_i)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // The table is stored with byte value 0 in the top element, hence ~index.
  assign {w0, w1, w2, w3} = key_i;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {SBOX[~rot[31:24]] ^ rcon, SBOX[~rot[23:16]], SBOX[~rot[15:8]], SBOX[~rot[7:0]]};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};
endmodule

// Byte-wise inverse S-box substitution.
module inv_subbytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = INV_SBOX[~data_i[8*i +: 8]];
  end
endmodule

// Row r of the column-major state rotates right by r bytes.
module inv_shiftrow (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign data_o[127-8*(4*c+r) -: 8] = data_i[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end
endmodule

// Column-wise multiply by {0e,0b,0d,09} over GF(2^8).
module inv_mixcolumns (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = data_i[127-32*c -: 32];
    assign data_o[127-32*c -: 32] = {
      m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
      m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3),
      m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3),
      m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3)
    };
  end
endmodule

// Top: control FSM, round-key bank and the shared round datapath.
module aes_inv_cipher_iter #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         ready,
  output logic         out_valid,
  output logic [127:0] data_out
);
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4
  } state_t;

  state_t        state_q;
  logic [127:0]  rk_q [0:10];
  logic [127:0]  st_q;
  logic [127:0]  ct_q;
  logic [3:0]    rc_q;
  logic          cache_valid_q;
  logic          ready_q;
  logic          out_valid_q;
  logic [127:0]  data_out_q;

  logic [127:0]  key_next_d;
  logic [127:0]  isr_d, isb_d, ark_d, imc_d;
  logic          cache_hit_d;

  // rc_q doubles as the expansion step and the round-key index.
  KeyGeneration u_keygen (
    .rc_i  (rc_q),
    .key_i (rk_q[rc_q]),
    .key_o (key_next_d)
  );

  inv_shiftrow   u_isr (.data_i(st_q),  .data_o(isr_d));
  inv_subbytes   u_isb (.data_i(isr_d), .data_o(isb_d));
  // In FINAL rc_q has reached 0, so ark_d is already the plaintext.
  assign ark_d = isb_d ^ rk_q[rc_q];
  inv_mixcolumns u_imc (.data_i(ark_d), .data_o(imc_d));

  assign cache_hit_d = (KEY_CACHE != 0) && cache_valid_q && (key_in == rk_q[0]);

  // Sequencer: accept, key expansion, initial AddRoundKey, 9 rounds, final round.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      st_q          <= '0;
      ct_q          <= '0;
      rc_q          <= '0;
      cache_valid_q <= 1'b0;
      ready_q       <= 1'b1;
      out_valid_q   <= 1'b0;
      data_out_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_KEYEXP: begin
          rk_q[rc_q + 4'd1] <= key_next_d;
          if (rc_q == 4'd9) begin
            cache_valid_q <= 1'b1;
            state_q       <= ST_INIT;
          end else begin
            rc_q <= rc_q + 4'd1;
          end
        end
        ST_INIT: begin
          st_q    <= ct_q ^ rk_q[10];
          rc_q    <= 4'd9;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          st_q <= imc_d;
          rc_q <= rc_q - 4'd1;
          if (rc_q == 4'd1) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          data_out_q  <= ark_d;
          out_valid_q <= 1'b1;
          ready_q     <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          if (start) begin
            ct_q    <= data_in;
            rk_q[0] <= key_in;
            rc_q    <= 4'd0;
            ready_q <= 1'b0;
            if (cache_hit_d) begin
              state_q <= ST_INIT;
            end else begin
              cache_valid_q <= 1'b0;
              state_q       <= ST_KEYEXP;
            end
          end
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_aes_inv_cipher_iter
// Description : Directed scoreboard bench for aes_inv_cipher_iter with one
//               caching instance and one KEY_CACHE=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clock = 1'b0;
  logic         reset, start, sel;
  logic [127:0] key_in, data_in;
  logic         start0, start1;
  logic         ready0, ready1, ov0, ov1;
  logic [127:0] dout0, dout1;
  logic         obs_ready, obs_valid;
  logic [127:0] obs_data;

  typedef struct {
    logic [127:0] pt;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign start0    = start && !sel;
  assign start1    = start && sel;
  assign obs_ready = sel ? ready1 : ready0;
  assign obs_valid = sel ? ov1 : ov0;
  assign obs_data  = sel ? dout1 : dout0;

  aes_inv_cipher_iter #(.KEY_CACHE(1)) dut (
    .clock(clock), .reset(reset), .start(start0), .key_in(key_in), .data_in(data_in),
    .ready(ready0), .out_valid(ov0), .data_out(dout0)
  );

  aes_inv_cipher_iter #(.KEY_CACHE(0)) dut_nc (
    .clock(clock), .reset(reset), .start(start1), .key_in(key_in), .data_in(data_in),
    .ready(ready1), .out_valid(ov1), .data_out(dout1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called one step after an edge with the core ready; the next edge accepts.
  task automatic launch(input string tag, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] p, input int l);
    chk({tag, "_accept_ready"}, obs_ready, 128'd1);
    key_in  = k;
    data_in = ct;
    start   = 1'b1;
    sb.push_back('{pt: p, lat: l});
  endtask

  // Consumes the accept edge, then waits for out_valid; p1/p2 pulse start while busy.
  task automatic collect(input string tag, input int p1, input int p2);
    int   lat;
    bit   done;
    exp_t e;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 0;
    done  = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      start = (lat == p1 || lat == p2);
      if (obs_valid) done = 1'b1;
      else chk({tag, "_busy_ready"}, obs_ready, 128'd0);
    end
    start = 1'b0;
    e = sb.pop_front();
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL %s_timeout observed=no_out_valid expected=out_valid_within_40", tag);
    end
    if (done) begin
      chk({tag, "_data"}, obs_data, e.pt);
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_done_ready"}, obs_ready, 128'd1);
    end
  endtask

  initial begin
    int extra;
    sel = 1'b0; reset = 1'b1; start = 1'b0; key_in = '0; data_in = '0;
    #1;
    chk("rst_ready", obs_ready, 128'd1);
    chk("rst_valid", obs_valid, 128'd0);
    chk("rst_data",  obs_data,  128'd0);
    #20 reset = 1'b0;
    @(posedge clock); #1;

    // Test 1: FIPS-197 C.1 with full expansion
    launch("t1", K1, CT1, PT1, 21);
    collect("t1", -1, -1);
    @(posedge clock); #1;
    chk("t1_pulse_end", obs_valid, 128'd0);
    chk("t1_hold", obs_data, PT1);

    // Test 2 then test 3 back-to-back in the completion cycle (cache hit)
    launch("t2", K2, CT2, PT2, 21);
    collect("t2", -1, -1);
    launch("t3_hit", K2, CT2, PT2, 11);
    collect("t3_hit", -1, -1);
    @(posedge clock); #1;
    chk("t3_pulse_end", obs_valid, 128'd0);
    chk("t3_hold", obs_data, PT2);

    // Test 4: start pulses while busy are dropped
    launch("t4", K1, CT1, PT1, 21);
    collect("t4", 3, 15);
    extra = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (obs_valid) extra++;
    end
    chk("t4_extra_pulses", extra, 128'd0);
    chk("t4_idle_ready", obs_ready, 128'd1);

    // Test 5: asynchronous reset mid-decrypt, then full-expansion rerun
    chk("t5_accept_ready", obs_ready, 128'd1);
    key_in = K1; data_in = CT1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t5_async_ready", obs_ready, 128'd1);
    chk("t5_async_valid", obs_valid, 128'd0);
    chk("t5_async_data",  obs_data,  128'd0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    chk("t5_post_valid", obs_valid, 128'd0);
    launch("t5_rerun", K1, CT1, PT1, 21);
    collect("t5_rerun", -1, -1);

    // Test 6: alternating keys, no stale cache hit
    launch("t6_a0", K2, CT2, PT2, 21);
    collect("t6_a0", -1, -1);
    launch("t6_b", K1, CT1, PT1, 21);
    collect("t6_b", -1, -1);
    launch("t6_a1", K2, CT2, PT2, 21);
    collect("t6_a1", -1, -1);
    @(posedge clock); #1;

    // Test 3 variant: KEY_CACHE=0 always expands
    sel = 1'b1;
    #1;
    launch("t3nc_0", K2, CT2, PT2, 21);
    collect("t3nc_0", -1, -1);
    launch("t3nc_1", K2, CT2, PT2, 21);
    collect("t3nc_1", -1, -1);
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
